// File: rtl/rtc_bus_pkg.sv
// ============================================================================
// Module : rtc_bus_pkg
// Shared constants, requester indices and FSM state type for the RTC arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rtc_bus_pkg;

    localparam int NREQ            = 5;
    localparam int REQ_INIT        = 0;
    localparam int REQ_RESET       = 1;
    localparam int REQ_WRITE       = 2;
    localparam int REQ_CRONO       = 3;
    localparam int REQ_READ        = 4;
    localparam int STARVE_LIM_DEF  = 8;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_prio_picker.sv
// ============================================================================
// Module : rtc_prio_picker
// Combinational fixed-priority picker (index 0 highest) with read promotion.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rtc_prio_picker
    import rtc_bus_pkg::*;
#(
    parameter int NREQ  = rtc_bus_pkg::NREQ,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic             promote_i,
    output logic [NREQ-1:0]  win_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        win_o   = '0;
        idx_o   = '0;
        valid_o = |req_i;
        if (promote_i && req_i[NREQ-1]) begin
            win_o[NREQ-1] = 1'b1;
            idx_o         = IDX_W'(NREQ - 1);
        end else begin
            // Scan downward so the lowest set index is the last one written.
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    win_o    = '0;
                    win_o[i] = 1'b1;
                    idx_o    = IDX_W'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rtc_bus_arbiter.sv
// ============================================================================
// Module : rtc_bus_arbiter
// Request/grant sequencer sharing one RTC protocol engine among NREQ users.
// Optional watchdog in WAIT enabled by macro RTC_ARB_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int NREQ        = rtc_bus_pkg::NREQ,
    parameter int STARVE_LIM  = STARVE_LIM_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   rnw_i,
    input  logic [8*NREQ-1:0] addr_bus_i,
    input  logic [8*NREQ-1:0] wdata_bus_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic [7:0]        rdata_o,
    output logic              busy_o,
    output logic              proto_start_o,
    output logic              proto_rnw_o,
    output logic [7:0]        proto_addr_o,
    output logic [7:0]        proto_wdata_o,
`ifdef RTC_ARB_TIMEOUT_EN
    output logic              timeout_err_o,
`endif
    input  logic              proto_done_i,
    input  logic [7:0]        proto_rdata_i
);

    localparam int IDX_W = idx_width(NREQ);

    if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_starve_lim
        $error("STARVE_LIM must fit the 4-bit starve counter");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout_cyc
        $error("TIMEOUT_CYC must fit the 8-bit watchdog");
    end

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic              rnw_q, rnw_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [3:0]        starve_q, starve_d;

    logic [NREQ-1:0]   win_onehot;
    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;

`ifdef RTC_ARB_TIMEOUT_EN
    logic [7:0]        wdog_q, wdog_d;
    logic              terr_q, terr_d;
`endif

    rtc_prio_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i     (req_i),
        .promote_i (starve_q == 4'(STARVE_LIM)),
        .win_o     (win_onehot),
        .idx_o     (win_idx),
        .valid_o   (win_valid)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        start_d  = 1'b0;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
`ifdef RTC_ARB_TIMEOUT_EN
        wdog_d   = 8'd0;
        terr_d   = terr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_ISSUE;
                    gnt_d   = win_onehot;
                    start_d = 1'b1;
                    rnw_d   = rnw_i[win_idx];
                    addr_d  = addr_bus_i[8*int'(win_idx) +: 8];
                    wdata_d = wdata_bus_i[8*int'(win_idx) +: 8];
                    if (win_onehot[NREQ-1]) begin
                        starve_d = 4'd0;
                    end else if (req_i[NREQ-1] && starve_q != 4'hF) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef RTC_ARB_TIMEOUT_EN
                wdog_d = wdog_q + 8'd1;
`endif
                if (proto_done_i) begin
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                    rdata_d = rnw_q ? proto_rdata_i : 8'h00;
`ifdef RTC_ARB_TIMEOUT_EN
                end else if (wdog_q == 8'(TIMEOUT_CYC - 1)) begin
                    // Engine never answered: complete with a recognisable pattern.
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                    rdata_d = 8'hFF;
                    terr_d  = 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            rnw_q    <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            rnw_q    <= rnw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

`ifdef RTC_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= 8'd0;
            terr_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err_o = terr_q;
`endif

    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign busy_o        = busy_q;
    assign proto_start_o = start_q;
    assign proto_rnw_o   = rnw_q;
    assign proto_addr_o  = addr_q;
    assign proto_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_arbiter.sv
// ============================================================================
// Module : tb_rtc_bus_arbiter
// Randomised self-checking bench for rtc_bus_arbiter against a priority model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rtc_bus_arbiter;

    localparam int N   = 5;
    localparam int LIM = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [N-1:0]     req_i;
    logic [N-1:0]     rnw_i;
    logic [8*N-1:0]   addr_bus_i;
    logic [8*N-1:0]   wdata_bus_i;
    logic [N-1:0]     gnt_o;
    logic [N-1:0]     done_o;
    logic [7:0]       rdata_o;
    logic             busy_o;
    logic             proto_start_o;
    logic             proto_rnw_o;
    logic [7:0]       proto_addr_o;
    logic [7:0]       proto_wdata_o;
    logic             proto_done_i;
    logic [7:0]       proto_rdata_i;
`ifdef RTC_ARB_TIMEOUT_EN
    logic             timeout_err_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int starve_m = 0;

    rtc_bus_arbiter dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .rnw_i         (rnw_i),
        .addr_bus_i    (addr_bus_i),
        .wdata_bus_i   (wdata_bus_i),
        .gnt_o         (gnt_o),
        .done_o        (done_o),
        .rdata_o       (rdata_o),
        .busy_o        (busy_o),
        .proto_start_o (proto_start_o),
        .proto_rnw_o   (proto_rnw_o),
        .proto_addr_o  (proto_addr_o),
        .proto_wdata_o (proto_wdata_o),
`ifdef RTC_ARB_TIMEOUT_EN
        .timeout_err_o (timeout_err_o),
`endif
        .proto_done_i  (proto_done_i),
        .proto_rdata_i (proto_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [8*N-1:0] rand_bus();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[8*N-1:0];
    endfunction

    // Reference arbitration: lowest index wins unless the read has lost LIM times in a row.
    function automatic int pick_winner(input logic [N-1:0] r);
        if (starve_m == LIM && r[N-1]) return N - 1;
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    // Entered at a negedge while the DUT is IDLE and req_i is non-zero; leaves at IDLE.
    task automatic run_txn(input bit keep, input int lat, input bit drop_early,
                           input bit stray, input logic [7:0] rd);
        int w;
        logic [7:0] ea, ed;
        logic er;
        logic [N-1:0] eg;
        w = pick_winner(req_i);
        if (w == N - 1) starve_m = 0;
        else if (req_i[N-1] && starve_m < 15) starve_m++;
        ea = addr_bus_i[8*w +: 8];
        ed = wdata_bus_i[8*w +: 8];
        er = rnw_i[w];
        eg = N'(1 << w);
        @(negedge clk_i);
        check_value("issue_start", proto_start_o, 1);
        check_value("issue_gnt", gnt_o, eg);
        check_value("issue_addr", proto_addr_o, ea);
        check_value("issue_wdata", proto_wdata_o, ed);
        check_value("issue_rnw", proto_rnw_o, er);
        check_value("issue_busy", busy_o, 1);
        if (drop_early && !keep) req_i[w] = 1'b0;
        proto_done_i = stray;
        @(negedge clk_i);
        proto_done_i = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            check_value("wait_hold", {proto_start_o, gnt_o, proto_addr_o, proto_wdata_o, proto_rnw_o, done_o},
                        {1'b0, eg, ea, ed, er, 5'b0});
            addr_bus_i  = rand_bus();
            wdata_bus_i = rand_bus();
            if (k < lat) @(negedge clk_i);
        end
        proto_done_i  = 1'b1;
        proto_rdata_i = rd;
        @(negedge clk_i);
        check_value("done_pulse", done_o, eg);
        check_value("done_rdata", rdata_o, er ? rd : 8'h00);
        check_value("done_gnt", {busy_o, gnt_o}, {1'b1, eg});
        if (!keep) req_i[w] = 1'b0;
        proto_done_i  = stray;
        proto_rdata_i = 8'($urandom);
        @(negedge clk_i);
        proto_done_i = 1'b0;
        check_value("idle_state", {done_o, gnt_o, busy_o, proto_start_o}, 12'h000);
    endtask

    initial begin
        int n;
        rst_i = 1'b1; req_i = '0; rnw_i = '0; addr_bus_i = '0; wdata_bus_i = '0;
        proto_done_i = 1'b0; proto_rdata_i = 8'h00;
        repeat (2) @(negedge clk_i);
        check_value("rst_ctrl", {gnt_o, done_o, busy_o, proto_start_o, proto_rnw_o}, 0);
        check_value("rst_data", {rdata_o, proto_addr_o, proto_wdata_o}, 0);
`ifdef RTC_ARB_TIMEOUT_EN
        check_value("rst_terr", timeout_err_o, 0);
`endif
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single write then single read
        req_i = 5'b00100; rnw_i = 5'b00000;
        addr_bus_i[23:16] = 8'h21; wdata_bus_i[23:16] = 8'h45;
        run_txn(1'b0, 2, 1'b0, 1'b0, 8'hA5);
        req_i = 5'b10000; rnw_i = 5'b10000; addr_bus_i[39:32] = 8'h22;
        run_txn(1'b0, 1, 1'b0, 1'b0, 8'h37);

        // Contention: 1, 3, 4 requested together
        req_i = 5'b11010; rnw_i = 5'($urandom);
        addr_bus_i = rand_bus(); wdata_bus_i = rand_bus();
        for (int t = 0; t < 3; t++) run_txn(1'b0, t, 1'b0, 1'b1, 8'($urandom));
        check_value("contention_drained", req_i, 0);

        // Starvation: write and read held continuously
        req_i = 5'b10100; rnw_i = 5'b10000;
        for (int t = 0; t < 18; t++) begin
            addr_bus_i = rand_bus(); wdata_bus_i = rand_bus();
            run_txn(1'b1, $urandom_range(0, 2), 1'b0, 1'b0, 8'($urandom));
            if (t == 8 || t == 17) check_value("starve_promoted", starve_m, 0);
        end
        req_i = '0;

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            req_i = req_i | (5'($urandom) & 5'($urandom));
            if (req_i == '0) req_i[$urandom_range(0, N-1)] = 1'b1;
            rnw_i = 5'($urandom);
            addr_bus_i = rand_bus(); wdata_bus_i = rand_bus();
            run_txn(($urandom % 4) == 0, $urandom_range(0, 4), ($urandom % 4) == 0,
                    ($urandom % 3) == 0, 8'($urandom));
        end

        // Reset in the middle of WAIT, then a late engine completion
        req_i = 5'b00001; rnw_i = 5'b00001;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check_value("async_rst_ctrl", {gnt_o, done_o, busy_o, proto_start_o, proto_rnw_o}, 0);
        check_value("async_rst_data", {rdata_o, proto_addr_o, proto_wdata_o}, 0);
        starve_m = 0;
        req_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        proto_done_i = 1'b1; proto_rdata_i = 8'h99;
        @(negedge clk_i);
        proto_done_i = 1'b0;
        check_value("late_done_ignored", {done_o, busy_o, rdata_o}, 0);
        @(negedge clk_i);
        check_value("still_idle", {done_o, gnt_o, busy_o}, 0);

`ifdef RTC_ARB_TIMEOUT_EN
        req_i = 5'b00001; rnw_i = 5'b00001;
        @(negedge clk_i);
        check_value("to_issue", proto_start_o, 1);
        req_i = '0;
        n = 0;
        while (done_o == '0 && n < 400) begin
            @(negedge clk_i);
            if (done_o == '0) n++;
        end
        check_value("to_wait_cycles", n, 255);
        check_value("to_done", done_o, 5'b00001);
        check_value("to_rdata", rdata_o, 8'hFF);
        check_value("to_err", timeout_err_o, 1);
        repeat (3) @(negedge clk_i);
        check_value("to_err_sticky", {timeout_err_o, busy_o}, 2'b10);
`else
        n = 0;
        check_value("no_timeout_idle", {busy_o, 31'(n)}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
